// File: rtl/aes_loader_pkg.sv
// Shared types and constants for the AES-128 block loader.
// Holds the loader FSM states and default geometry.
package aes_loader_pkg;

  typedef enum logic [1:0] {
    WAIT_KEY = 2'd0,
    COLLECT  = 2'd1,
    ISSUE    = 2'd2
  } state_t;

  localparam int DEF_WORD_W       = 32;
  localparam int WORDS_PER_BLK    = 128 / DEF_WORD_W;
  localparam int DEF_CORE_LATENCY = 10;

endpackage

// File: rtl/aes_loader_if.sv
// Stream-side key/plaintext/ciphertext bundle of the AES loader.
// master drives words in; slave is the loader.
interface aes_loader_if #(
  parameter int WORD_W = 32
) ();

  logic              key_wr;
  logic [WORD_W-1:0] key_word;
  logic              in_valid;
  logic [WORD_W-1:0] in_word;
  logic              in_ready;
  logic              key_loaded;
  logic              key_err;
  logic              out_valid;
  logic [127:0]      out_block;

  modport master (
    output key_wr, key_word,
    output in_valid, in_word,
    input  in_ready, key_loaded,
    input  key_err, out_valid,
    input  out_block
  );

  modport slave (
    input  key_wr, key_word,
    input  in_valid, in_word,
    output in_ready, key_loaded,
    output key_err, out_valid,
    output out_block
  );

endinterface

// File: rtl/aes_valid_pipe.sv
// Fixed-depth 1-bit shift register tagging blocks
// through the AES core latency.
module aes_valid_pipe #(
  parameter int DEPTH = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] stg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stg <= '0;
    end else begin
      stg[0] <= din;
      for (int i = 1; i < DEPTH; i++)
        stg[i] <= stg[i-1];
    end
  end

  assign dout = stg[DEPTH-1];

endmodule

// File: rtl/aes_block_loader.sv
// Assembles key and plaintext words into 128-bit registers,
// issues blocks to the AES core and tags its output valid.
module aes_block_loader
  import aes_loader_pkg::*;
#(
  parameter int WORD_W       = DEF_WORD_W,
  parameter int CORE_LATENCY = DEF_CORE_LATENCY
) (
  input  logic         clk,
  input  logic         rst,
  aes_loader_if.slave  bus,
  output logic [127:0] core_data,
  output logic [127:0] core_key,
  input  logic [127:0] core_out
);

  localparam int NW = 128 / WORD_W;
  localparam int CW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [CW-1:0] LAST = CW'(NW - 1);

  state_t state, state_n;

  logic [CW-1:0] key_cnt;
  logic [CW-1:0] word_cnt;
  logic [127:0]  key_shift;
  logic [127:0]  blk_shift;
  logic [127:0]  key_asm;
  logic [127:0]  blk_asm;
  logic          key_loaded_q;
  logic          key_err_q;

  logic rdy;
  logic key_take;
  logic key_restart;
  logic blk_take;
  logic issue;
  logic err_n;

  assign key_asm = {key_shift[127-WORD_W:0], bus.key_word};
  assign blk_asm = {blk_shift[127-WORD_W:0], bus.in_word};

  always_comb begin
    state_n     = state;
    rdy         = 1'b0;
    key_take    = 1'b0;
    key_restart = 1'b0;
    blk_take    = 1'b0;
    issue       = 1'b0;
    err_n       = 1'b0;
    unique case (state)
      WAIT_KEY: begin
        if (bus.key_wr) begin
          key_take = 1'b1;
          if (key_cnt == LAST)
            state_n = COLLECT;
        end
      end
      COLLECT: begin
        rdy = !bus.key_wr;
        // a key write between blocks starts a new key
        if (bus.key_wr) begin
          if (word_cnt == '0) begin
            key_restart = 1'b1;
            state_n     = WAIT_KEY;
          end else begin
            err_n = 1'b1;
          end
        end else if (bus.in_valid) begin
          blk_take = 1'b1;
          if (word_cnt == LAST)
            state_n = ISSUE;
        end
      end
      ISSUE: begin
        issue   = 1'b1;
        err_n   = bus.key_wr;
        state_n = COLLECT;
      end
      default: state_n = WAIT_KEY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= WAIT_KEY;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_cnt      <= '0;
      word_cnt     <= '0;
      key_shift    <= '0;
      blk_shift    <= '0;
      core_key     <= '0;
      core_data    <= '0;
      key_loaded_q <= 1'b0;
      key_err_q    <= 1'b0;
    end else begin
      key_err_q <= err_n;
      if (key_take || key_restart)
        key_shift <= key_asm;
      if (key_take) begin
        if (key_cnt == LAST) begin
          key_cnt      <= '0;
          core_key     <= key_asm;
          key_loaded_q <= 1'b1;
        end else begin
          key_cnt <= key_cnt + 1'b1;
        end
      end
      if (key_restart) begin
        key_cnt      <= CW'(1);
        key_loaded_q <= 1'b0;
      end
      if (blk_take) begin
        blk_shift <= blk_asm;
        if (word_cnt == LAST) begin
          word_cnt  <= '0;
          core_data <= blk_asm;
        end else begin
          word_cnt <= word_cnt + 1'b1;
        end
      end
    end
  end

  aes_valid_pipe #(
    .DEPTH (CORE_LATENCY)
  ) u_vpipe (
    .clk  (clk),
    .rst  (rst),
    .din  (issue),
    .dout (bus.out_valid)
  );

  assign bus.in_ready   = rdy;
  assign bus.key_loaded = key_loaded_q;
  assign bus.key_err    = key_err_q;
  assign bus.out_block  = core_out;

endmodule

// File: tb/tb_aes_block_loader.sv
// Bench for aes_block_loader: stand-in AES core, queue-based
// reference model, FIPS table, corner sequences, random traffic.
module tb_aes_block_loader;
  import aes_loader_pkg::*;

  localparam int LAT = DEF_CORE_LATENCY;
  localparam logic [127:0] F_KEY =
    128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] F_PT =
    128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] F_CT =
    128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [127:0] core_data, core_key, core_out;

  aes_loader_if #(.WORD_W(32)) bus ();

  aes_block_loader #(
    .WORD_W       (32),
    .CORE_LATENCY (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .core_data (core_data),
    .core_key  (core_key),
    .core_out  (core_out)
  );

  always #5 clk = ~clk;

  // Stand-in core: known answer for FIPS pair, cheap mix otherwise
  function automatic logic [127:0] core_f(
    input logic [127:0] d, input logic [127:0] k);
    if (d == F_PT && k == F_KEY) return F_CT;
    return d ^ {k[63:0], k[127:64]} ^ 128'h5a5a_0f0f_3c3c_9696_a5a5_f0f0_c3c3_6969;
  endfunction

  logic [127:0] cpipe [LAT];
  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) cpipe[i] <= cpipe[i-1];
    cpipe[0] <= core_f(core_data, core_key);
  end
  assign core_out = cpipe[LAT-1];

  typedef struct {
    int           due;
    logic [127:0] ct;
  } exp_t;

  typedef struct {
    bit          kwr;
    bit          iv;
    logic [31:0] w;
    bit          e_rdy;
    bit          e_ld;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bit           m_loaded, m_issue, m_err;
  logic [31:0]  kq[$];
  logic [31:0]  bq[$];
  logic [127:0] m_key, m_blk;
  exp_t         eq[$];
  int           vq[$];
  bit           l_rdy, l_ld, l_err;
  logic [127:0] l_ob;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h",
               nm, cyc, act, exp);
    end
  endtask

  function automatic logic [127:0] pack4(input logic [31:0] w[$]);
    return {w[0], w[1], w[2], w[3]};
  endfunction

  task automatic model_clear();
    m_loaded = 0; m_issue = 0; m_err = 0;
    kq.delete(); bq.delete(); eq.delete();
    m_key = '0; m_blk = '0;
  endtask

  // One clock cycle: drive, check against model, advance model
  task automatic step(input bit kwr, input logic [31:0] kwd,
                      input bit iv, input logic [31:0] iwd);
    bit e_rdy, e_v;
    bus.key_wr = kwr; bus.key_word = kwd;
    bus.in_valid = iv; bus.in_word = iwd;
    e_rdy = m_loaded && !m_issue && !kwr;
    e_v = eq.size() > 0 && eq[0].due == cyc;
    @(negedge clk);
    l_rdy = bus.in_ready; l_ld = bus.key_loaded;
    l_err = bus.key_err; l_ob = bus.out_block;
    chk("in_ready", bus.in_ready, e_rdy);
    chk("key_loaded", bus.key_loaded, m_loaded);
    chk("key_err", bus.key_err, m_err);
    chk("out_valid", bus.out_valid, e_v);
    if (e_v) begin
      chk("out_block", bus.out_block, eq[0].ct);
      void'(eq.pop_front());
    end
    chk("core_key", core_key, m_key);
    chk("core_data", core_data, m_blk);
    if (bus.out_valid) vq.push_back(cyc);
    m_err = kwr && (m_issue || (m_loaded && bq.size() != 0));
    if (m_issue) begin
      m_issue = 0;
      eq.push_back('{cyc + LAT, core_f(m_blk, m_key)});
    end else if (!m_loaded) begin
      if (kwr) begin
        kq.push_back(kwd);
        if (kq.size() == WORDS_PER_BLK) begin
          m_key = pack4(kq); kq.delete(); m_loaded = 1;
        end
      end
    end else if (kwr) begin
      if (bq.size() == 0) begin
        m_loaded = 0; kq.delete(); kq.push_back(kwd);
      end
    end else if (iv) begin
      bq.push_back(iwd);
      if (bq.size() == WORDS_PER_BLK) begin
        m_blk = pack4(bq); bq.delete(); m_issue = 1;
      end
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, '0);
  endtask

  task automatic do_reset();
    bus.key_wr = 0; bus.key_word = '0;
    bus.in_valid = 0; bus.in_word = '0;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    model_clear();
    cyc++;
  endtask

  vec_t tv[9];
  int   iss;
  bit   got_ct;

  initial begin
    tv[0] = '{1, 0, 32'h00010203, 0, 0};
    tv[1] = '{1, 0, 32'h04050607, 0, 0};
    tv[2] = '{1, 0, 32'h08090a0b, 0, 0};
    tv[3] = '{1, 0, 32'h0c0d0e0f, 0, 0};
    tv[4] = '{0, 1, 32'h00112233, 1, 1};
    tv[5] = '{0, 1, 32'h44556677, 1, 1};
    tv[6] = '{0, 1, 32'h8899aabb, 1, 1};
    tv[7] = '{0, 1, 32'hccddeeff, 1, 1};
    tv[8] = '{0, 0, 32'h0, 0, 1};

    do_reset();
    idle(2);

    // FIPS-197 vector
    iss = 0;
    for (int i = 0; i < 9; i++) begin
      if (i == 8) iss = cyc;
      step(tv[i].kwr, tv[i].w, tv[i].iv, tv[i].w);
      chk("tv_in_ready", l_rdy, tv[i].e_rdy);
      chk("tv_key_loaded", l_ld, tv[i].e_ld);
    end
    chk("fips_core_key", core_key, F_KEY);
    chk("fips_core_data", core_data, F_PT);
    vq.delete();
    got_ct = 0;
    for (int i = 0; i < LAT + 2; i++) begin
      step(0, '0, 0, '0);
      if (vq.size() > 0 && !got_ct) begin
        got_ct = 1;
        chk("fips_ct", l_ob, F_CT);
      end
    end
    chk("fips_lat", vq.size() > 0 ? vq[0] - iss : -1, LAT);

    // back-to-back, in_valid held high
    vq.delete();
    for (int i = 0; i < 15; i++) step(0, '0, 1, $urandom);
    idle(LAT + 2);
    chk("b2b_count", vq.size(), 3);
    if (vq.size() == 3) begin
      chk("b2b_gap0", vq[1] - vq[0], 5);
      chk("b2b_gap1", vq[2] - vq[1], 5);
    end

    // ragged input with 2-cycle gaps
    vq.delete();
    step(0, '0, 1, 32'hA0A0A0A0); idle(2);
    step(0, '0, 1, 32'hA1A1A1A1); idle(2);
    step(0, '0, 1, 32'hA2A2A2A2);
    step(0, '0, 1, 32'hA3A3A3A3);
    idle(LAT + 2);
    chk("ragged_count", vq.size(), 1);
    chk("ragged_data", core_data,
        128'hA0A0A0A0A1A1A1A1A2A2A2A2A3A3A3A3);

    // key write mid-block is ignored
    step(0, '0, 1, 32'h11111111);
    step(0, '0, 1, 32'h22222222);
    step(1, 32'hDEADBEEF, 1, 32'h33333333);
    step(0, '0, 0, '0);
    chk("kerr_pulse", l_err, 1);
    step(0, '0, 0, '0);
    chk("kerr_one_cycle", l_err, 0);
    chk("kerr_key_kept", core_key, F_KEY);
    step(0, '0, 1, 32'h33333333);
    step(0, '0, 1, 32'h44444444);
    idle(LAT + 2);

    // key reload at a block boundary with in_valid high
    step(1, 32'hCAFE0001, 1, 32'h99999999);
    chk("reload_no_accept", l_rdy, 0);
    step(1, 32'hCAFE0002, 1, 32'h99999999);
    chk("reload_ld_low", l_ld, 0);
    step(1, 32'hCAFE0003, 1, 32'h99999999);
    step(1, 32'hCAFE0004, 1, 32'h99999999);
    for (int i = 0; i < 4; i++) step(0, '0, 1, $urandom);
    chk("reload_key", core_key,
        128'hCAFE0001CAFE0002CAFE0003CAFE0004);
    idle(LAT + 2);

    // reset 3 cycles after ISSUE
    for (int i = 0; i < 4; i++) step(0, '0, 1, $urandom);
    idle(3);
    do_reset();
    vq.delete();
    idle(LAT + 2);
    chk("rst_no_valid", vq.size(), 0);
    chk("rst_key_loaded", l_ld, 0);
    chk("rst_in_ready", l_rdy, 0);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      bit kw, iv;
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        kw = m_loaded ? ($urandom_range(0, 19) == 0)
                      : ($urandom_range(0, 1) == 0);
        iv = $urandom_range(0, 3) != 0;
        step(kw, $urandom, iv, $urandom);
      end
    end
    idle(LAT + 2);
    chk("rand_drained", eq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_block_loader.md
Name: aes_block_loader

Overview:
- Upstream feeder for the 10-round pipelined AES-128 encryption core.
- Assembles 32-bit key words and plaintext words into 128-bit key/block registers, then issues each block to the core.
- Tracks each issued block through the core's fixed latency with a valid shift register, so the core's 128-bit output is tagged with out_valid.
- Owns the stream-side valid/ready handshake; the core itself has no handshake.

Parameters:
- WORD_W, 32, width of the key and plaintext input words; 128/WORD_W words per block (4 at default).
- CORE_LATENCY, 10, clock cycles from the core sampling data_in/key to the matching data_out.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- key_wr  in  1  key word strobe
- key_word  in  WORD_W  key word; first word -> bits [127:96]
- in_valid  in  1  plaintext word valid
- in_word  in  WORD_W  plaintext word; first word -> bits [127:96]
- in_ready  out  1  plaintext word accepted when in_valid && in_ready
- key_loaded  out  1  full 128-bit key held
- key_err  out  1  one-cycle pulse: key_wr ignored
- core_data  out  128  to core data_in
- core_key  out  128  to core key
- core_out  in  128  from core data_out
- out_valid  out  1  core_out is a valid ciphertext this cycle
- out_block  out  128  ciphertext (= core_out)

Behaviour:
- Single clock domain.
- Reset (rst=1 at a clock edge; also applies mid-operation):
  - state=WAIT_KEY; key_cnt=0; word_cnt=0; valid shift register cleared.
  - Outputs: in_ready=0, key_loaded=0, key_err=0, core_data=0, core_key=0, out_valid=0.
  - Blocks in flight are discarded (never flagged valid).
- FSM states:
  - WAIT_KEY: each key_wr shifts key_word into key_shift and increments key_cnt. At the 4th word, core_key takes the assembled key, key_loaded goes 1, next state is COLLECT.
  - COLLECT:
    - in_ready = !key_wr (combinational).
    - Each accepted word shifts into blk_shift and increments word_cnt.
    - On the 4th accepted word: core_data takes the assembled block, word_cnt returns to 0, next state is ISSUE.
    - key_wr with word_cnt==0: treated as the first word of a new key (key_cnt=1), key_loaded drops to 0, next state is WAIT_KEY. A simultaneous in_valid is not accepted.
    - key_wr with word_cnt!=0: ignored; key_err pulses 1 for one cycle.
  - ISSUE: lasts exactly one cycle. in_ready=0. A 1 is shifted into the valid pipe. Next state is COLLECT. key_wr here is ignored and key_err pulses.
- Stability: core_data and core_key hold their values until the next assembly completes. The core may sample them every cycle; only the ISSUE-cycle sample is tagged.
- Valid pipe: CORE_LATENCY-deep shift register, shifting every cycle. out_valid = last stage.
  - Block issued at ISSUE cycle N -> out_valid=1 at cycle N+CORE_LATENCY.
  - Every non-ISSUE cycle inserts 0.
- out_block = core_out, unregistered.
- Throughput: one block per 5 cycles at best (4 accept cycles + 1 issue cycle). No output back-pressure; downstream must always accept.
- Key reload: blocks already issued keep their old key, because the core carries round keys alongside data. Blocks issued after reload use the new key.
- Stalls: in_valid=0 during COLLECT holds word_cnt. Partial blocks are retained indefinitely.
- Width rules: counters are 2 bits and wrap 3->0 only on completion.

Decomposition:
- Package aes_loader_pkg holds:
  - state enum {WAIT_KEY, COLLECT, ISSUE};
  - WORDS_PER_BLK = 128/WORD_W;
  - default CORE_LATENCY.
- One sub-module, aes_valid_pipe: parameterised-depth 1-bit shift register with synchronous reset.

Test Plan:
- FIPS-197 vector: key words 00010203, 04050607, 08090a0b, 0c0d0e0f; then plaintext words 00112233, 44556677, 8899aabb, ccddeeff. Required: core_key=000102030405060708090a0b0c0d0e0f and core_data=00112233445566778899aabbccddeeff after the last word; out_valid exactly CORE_LATENCY cycles after ISSUE; out_block=69c4e0d86a7b0430d8cdb78070b4c55a.
- Back-to-back: 3 blocks with in_valid held high -> in_ready pattern 1,1,1,1,0 repeating; out_valid pulses spaced exactly 5 cycles apart.
- Ragged input: in_valid toggling, 2-cycle gaps mid-block -> block assembled in correct word order; exactly one out_valid per block.
- Key error: key_wr after 2 accepted plaintext words -> key_err=1 for one cycle; core_key unchanged; block completes normally.
- Key reload at word_cnt==0 with in_valid also high -> word not accepted; key_loaded=0 until 4 key words written; first block issued afterwards uses the new key.
- Reset mid-flight: rst asserted 3 cycles after ISSUE -> out_valid stays 0 for the following CORE_LATENCY cycles; key_loaded=0; in_ready=0 until a key is reloaded.
